// File: rtl/universal_register.sv
// Multi-mode register: hold, load, shift, rotate, increment and decrement, with a carry/shift-out bit and a zero flag.
// Defining UREG_PARITY_EN adds o_parity, the registered even parity of the value written into o_data_out.
module universal_register #(
   parameter int unsigned         WIDTH   = 8,
   parameter logic [WIDTH-1:0]    RST_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [2:0]       i_mode,
   input  logic             i_ser_in,
   input  logic [WIDTH-1:0] i_data_in,
   output logic [WIDTH-1:0] o_data_out,
   output logic             o_carry,
   output logic             o_zero
`ifdef UREG_PARITY_EN
   ,
   output logic             o_parity
`endif
);

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_ROR  = 3'b101,
      MODE_INC  = 3'b110,
      MODE_DEC  = 3'b111
   } mode_t;

   logic [WIDTH-1:0] r_data;
   logic             r_carry;
   logic [WIDTH-1:0] w_data_nxt;
   logic             w_carry_nxt;
   logic [WIDTH:0]   w_inc_sum;

   assign w_inc_sum = {1'b0, r_data} + {{WIDTH{1'b0}}, 1'b1};

   // Priority is clr, then enable, then mode. An unknown mode must poison the data
   // in simulation rather than quietly holding, hence the X default.
   always_comb begin
      w_data_nxt  = r_data;
      w_carry_nxt = r_carry;
      if (i_clr) begin
         w_data_nxt  = '0;
         w_carry_nxt = 1'b0;
      end else if (i_en) begin
         case (i_mode)
            MODE_HOLD: begin
               w_data_nxt  = r_data;
               w_carry_nxt = r_carry;
            end
            MODE_LOAD: begin
               w_data_nxt  = i_data_in;
               w_carry_nxt = 1'b0;
            end
            MODE_SHL: begin
               w_data_nxt  = {r_data[WIDTH-2:0], i_ser_in};
               w_carry_nxt = r_data[WIDTH-1];
            end
            MODE_SHR: begin
               w_data_nxt  = {i_ser_in, r_data[WIDTH-1:1]};
               w_carry_nxt = r_data[0];
            end
            MODE_ROL: begin
               w_data_nxt  = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
               w_carry_nxt = r_data[WIDTH-1];
            end
            MODE_ROR: begin
               w_data_nxt  = {r_data[0], r_data[WIDTH-1:1]};
               w_carry_nxt = r_data[0];
            end
            MODE_INC: begin
               w_data_nxt  = w_inc_sum[WIDTH-1:0];
               w_carry_nxt = w_inc_sum[WIDTH];
            end
            MODE_DEC: begin
               w_data_nxt  = r_data - {{(WIDTH-1){1'b0}}, 1'b1};
               w_carry_nxt = (r_data == '0);
            end
            default: begin
               w_data_nxt  = 'x;
               w_carry_nxt = 1'bx;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data  <= RST_VAL;
         r_carry <= 1'b0;
      end else begin
         r_data  <= w_data_nxt;
         r_carry <= w_carry_nxt;
      end
   end

   assign o_data_out = r_data;
   assign o_carry    = r_carry;
   assign o_zero     = (r_data == '0);

`ifdef UREG_PARITY_EN
   logic r_parity;

   // Parity of the held value equals the stored parity, so tracking w_data_nxt every edge also covers hold.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_parity <= ^RST_VAL;
      end else begin
         r_parity <= ^w_data_nxt;
      end
   end

   assign o_parity = r_parity;
`endif

endmodule

// File: tb/tb_universal_register.sv
// Directed bench for universal_register (WIDTH=8, RST_VAL=0); inputs driven on negedge, outputs checked on the next negedge.
module tb_universal_register;

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_LOAD = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_SHR  = 3'b011;
   localparam logic [2:0] M_ROL  = 3'b100;
   localparam logic [2:0] M_ROR  = 3'b101;
   localparam logic [2:0] M_INC  = 3'b110;
   localparam logic [2:0] M_DEC  = 3'b111;

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic       en;
   logic [2:0] mode;
   logic       ser_in;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       carry;
   logic       zero;
`ifdef UREG_PARITY_EN
   logic       parity;
`endif

   int n_vec = 0;
   int n_err = 0;

   universal_register #(.WIDTH(8), .RST_VAL(8'h00)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_clr      (clr),
      .i_en       (en),
      .i_mode     (mode),
      .i_ser_in   (ser_in),
      .i_data_in  (data_in),
      .o_data_out (data_out),
      .o_carry    (carry),
      .o_zero     (zero)
`ifdef UREG_PARITY_EN
      ,
      .o_parity   (parity)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_state(input string tag, input logic [7:0] exp_d, input logic exp_c);
      chk({tag, " data"},  data_out,      exp_d);
      chk({tag, " carry"}, {7'd0, carry}, {7'd0, exp_c});
      chk({tag, " zero"},  {7'd0, zero},  {7'd0, (exp_d == 8'h00)});
   endtask

   task automatic step(input logic c, input logic e, input logic [2:0] m,
                       input logic s, input logic [7:0] d);
      clr     = c;
      en      = e;
      mode    = m;
      ser_in  = s;
      data_in = d;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; en = 1'b0; mode = M_HOLD; ser_in = 1'b0; data_in = 8'h00;
      @(negedge clk);
      @(negedge clk);
      expect_state("reset", 8'h00, 1'b0);
`ifdef UREG_PARITY_EN
      chk("reset parity", {7'd0, parity}, 8'h00);
`endif
      rst_n = 1'b1;

      // 1: asynchronous reset mid-cycle after a load
      step(0, 1, M_LOAD, 0, 8'h55);
      expect_state("load55", 8'h55, 1'b0);
      en = 1'b0;
      #2 rst_n = 1'b0;
      #1 expect_state("async rst", 8'h00, 1'b0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      expect_state("post rst", 8'h00, 1'b0);

      // 2: shifts
      step(0, 1, M_LOAD, 0, 8'hA5);
      expect_state("loadA5", 8'hA5, 1'b0);
      step(0, 1, M_SHL, 1, 8'h00);
      expect_state("shl", 8'h4B, 1'b1);
      step(0, 1, M_SHR, 0, 8'h00);
      expect_state("shr", 8'h25, 1'b1);

      // 3: rotates and HOLD
      step(0, 1, M_LOAD, 0, 8'h81);
      expect_state("load81", 8'h81, 1'b0);
      step(0, 1, M_ROL, 0, 8'h00);
      expect_state("rol", 8'h03, 1'b1);
      step(0, 1, M_ROR, 0, 8'h00);
      expect_state("ror1", 8'h81, 1'b1);
      step(0, 1, M_ROR, 0, 8'h00);
      expect_state("ror2", 8'hC0, 1'b1);
      step(0, 1, M_HOLD, 1, 8'hFF);
      expect_state("hold", 8'hC0, 1'b1);

      // 4: increment/decrement wrap
      step(0, 1, M_LOAD, 0, 8'hFE);
      step(0, 1, M_INC, 0, 8'h00);
      expect_state("inc FE", 8'hFF, 1'b0);
      step(0, 1, M_INC, 0, 8'h00);
      expect_state("inc FF", 8'h00, 1'b1);
      step(0, 1, M_DEC, 0, 8'h00);
      expect_state("dec 00", 8'hFF, 1'b1);
      step(0, 1, M_LOAD, 0, 8'h05);
      step(0, 1, M_DEC, 0, 8'h00);
      expect_state("dec 05", 8'h04, 1'b0);

      // 5: enable low holds, clear wins over disable and over load
      step(0, 1, M_LOAD, 0, 8'h3C);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, M_INC, 0, 8'h00);
         expect_state("en0 hold", 8'h3C, 1'b0);
      end
      step(1, 0, M_INC, 0, 8'h00);
      expect_state("clr en0", 8'h00, 1'b0);
      step(0, 1, M_LOAD, 0, 8'h80);
      step(0, 1, M_SHL, 0, 8'h00);
      expect_state("shl 80", 8'h00, 1'b1);
      step(1, 1, M_LOAD, 0, 8'hFF);
      expect_state("clr over load", 8'h00, 1'b0);

`ifdef UREG_PARITY_EN
      // 6: parity
      step(0, 1, M_LOAD, 0, 8'h07);
      chk("parity 07", {7'd0, parity}, 8'h01);
      step(0, 0, M_LOAD, 0, 8'h03);
      chk("parity hold", {7'd0, parity}, 8'h01);
      step(0, 1, M_LOAD, 0, 8'h03);
      chk("parity 03", {7'd0, parity}, 8'h00);
      step(0, 1, M_LOAD, 0, 8'h01);
      chk("parity 01", {7'd0, parity}, 8'h01);
      step(1, 1, M_HOLD, 0, 8'h00);
      chk("parity clr", {7'd0, parity}, 8'h00);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
